dcache_responder: RTL
=====================

# dcache_responder

Direct-mapped, write-through data cache that answers the processor controller's `MemRead`/`MemWrite` requests and stalls it via `busy`. It sits between the controller/datapath and the slow data memory, acting as responder toward the controller and as initiator toward memory over a req/ack handshake. Read hits return in the request cycle. Read misses fill one word from memory. Every write goes through to memory.

## Interface
- `NBITS`, 8: data and address width.
- `NLINES`, 4: number of lines, power of two; one word per line.
- `CNTBITS`, 16: width of the performance counters.

- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `MemRead`  in  1: read request, held by the controller while `busy`.
- `MemWrite`  in  1: write request, held while `busy`; has priority over `MemRead`.
- `address`  in  NBITS: word address. Index = `address[$clog2(NLINES)-1:0]`, tag = remaining upper bits.
- `WriteData`  in  NBITS: store data.
- `ReadData`  out  NBITS: load data, valid when `MemRead & !busy`.
- `busy`  out  1: controller must hold its request and PC.
- `mem_req`  out  1: memory request, held until `mem_ack`.
- `mem_we`  out  1: 1 = write, 0 = read; stable while `mem_req`.
- `mem_addr`  out  NBITS: latched request address.
- `mem_wdata`  out  NBITS: latched store data.
- `mem_rdata`  in  NBITS: fill data, valid with `mem_ack`.
- `mem_ack`  in  1: single-cycle acknowledge.
- `hit_count`, `miss_count`  out  CNTBITS: read hit and miss counters; wrap at 2^CNTBITS.

## Operation
- FSM states:
  - **IDLE**
    - read hit (`MemRead & !MemWrite`, line valid, tag match): `ReadData` = line data, `busy` = 0, stay in IDLE, `hit_count`++.
    - read miss: `busy` = 1, latch `address`, go to FILL, `miss_count`++.
    - `MemWrite`: `busy` = 1, latch `address` and `WriteData`, go to WRITE. On a tag match the line data is updated at this edge. No write-allocate.
  - **FILL**
    - `mem_req` = 1, `mem_we` = 0, `busy` = 1.
    - On `mem_ack`: write `mem_rdata` into the line, set valid and tag, go to IDLE.
    - The next cycle the held request hits. That hit is not counted.
  - **WRITE**
    - `mem_req` = 1, `mem_we` = 1, `busy` = `!mem_ack`.
    - On `mem_ack`: go to IDLE.
- No request (`MemRead` = `MemWrite` = 0): `busy` = 0, no state change, counters hold.
- `ReadData` = 0 whenever no read hit is being returned.
- Inputs are ignored outside IDLE. The latched copies drive the memory side.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered outputs. `busy` and `ReadData` are combinational.

## Timing
- Read hit latency: 0 cycles, with `busy` never asserted.
- Read miss: `busy` is high from the request cycle through the `mem_ack` cycle, then low the following cycle. Total stall = L + 1 cycles, where `mem_ack` arrives L cycles after `mem_req` rises.
- Write: `busy` is high from the request cycle and drops in the `mem_ack` cycle. Stall = L cycles.
- `mem_req` rises the cycle after the request is accepted and falls the cycle after `mem_ack`.
- A `mem_ack` seen in IDLE is ignored.
- Reset values: state IDLE, all valid bits 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, counters 0. `busy` = 0 and `ReadData` = 0 during the reset cycle.
- Reset during FILL or WRITE aborts the transaction:
  - `mem_req` drops after the reset edge.
  - A later stray `mem_ack` is ignored.
  - A half-done fill never sets valid.
- Index aliasing: a fill replaces the line unconditionally. No eviction traffic is needed, since the cache is write-through.

## Structure
- Shared package `riscv_pkg`: `dcache_state_t` enum {IDLE, FILL, WRITE}.
- Sub-module `dcache_array`: valid/tag/data storage.
  - Combinational read by index.
  - Synchronous write port.
  - Synchronous clear of valid bits on `reset`.
- The FSM and counters live in `dcache_responder`.

## Test plan
- **Cold read miss:** reset, then `MemRead`, `address` = 0x15, memory returns 0xA7 with L = 3. Required: `busy` high 4 cycles, then `ReadData` = 0xA7 with `busy` = 0; `miss_count` = 1, `hit_count` = 0.
- **Hit after fill:** repeat the read of 0x15. Required: `ReadData` = 0xA7 in the same cycle, `busy` never high, `mem_req` never high, `hit_count` = 1.
- **Write-through hit:** `MemWrite` 0x15 ← 0x3C with L = 2. Required: `mem_we` = 1, `mem_addr` = 0x15, `mem_wdata` = 0x3C; `busy` drops in the ack cycle; a following read of 0x15 returns 0x3C with no miss.
- **Write miss, no allocate:** write 0x22 ← 0x11, then read 0x22. Required: the read misses and a fill is issued.
- **Alias:** read 0x01 (memory 0x55), then 0x05 (memory 0x66), then 0x01 again. Required: three misses; final `ReadData` = 0x55.
- **Reset mid-FILL:** assert `reset` one cycle after `mem_req` rises, pulse `mem_ack` two cycles later. Required: `mem_req` = 0 after the reset edge, the line stays invalid, and the next read of that address misses.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared processor-side types; the data cache takes its controller FSM encoding from here.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

endpackage

// File: rtl/dcache_responder_if.sv
// Cache-to-memory request bus: the cache is master, the data memory is slave.
interface dcache_responder_if #(
    parameter int NBITS = 8
) ();
    // Handshake: master raises mem_req with mem_we/mem_addr/mem_wdata stable and holds
    // them until the slave answers with a one-cycle mem_ack (mem_rdata valid with it);
    // mem_req drops the cycle after mem_ack.
    logic             mem_req;
    logic             mem_we;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic [NBITS-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
module dcache_array #(
    parameter  int NBITS  = 8,
    parameter  int NLINES = 4,
    localparam int IDXW   = $clog2(NLINES),
    localparam int TAGW   = NBITS - IDXW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDXW-1:0]  rd_index,
    output logic             rd_valid,
    output logic [TAGW-1:0]  rd_tag,
    output logic [NBITS-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_index,
    input  logic [TAGW-1:0]  wr_tag,
    input  logic [NBITS-1:0] wr_data
);
    logic [NLINES-1:0] valid;
    logic [TAGW-1:0]   tags  [NLINES];
    logic [NBITS-1:0]  words [NLINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

    // Only valid bits need clearing; tag/data are don't-care while invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through data cache: answers controller loads/stores, stalls via busy,
// and fills/writes through to data memory over the req/ack bus.
module dcache_responder
    import riscv_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NLINES  = 4,
    parameter int CNTBITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [NBITS-1:0]    address,
    input  logic [NBITS-1:0]    WriteData,
    output logic [NBITS-1:0]    ReadData,
    output logic                busy,
    dcache_responder_if.master  mem,
    output logic [CNTBITS-1:0]  hit_count,
    output logic [CNTBITS-1:0]  miss_count,
    output dcache_state_t       dbg_state
);
    localparam int IDXW = $clog2(NLINES);
    localparam int TAGW = NBITS - IDXW;
    localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

    dcache_state_t    state;
    logic             fill_done;
    logic [IDXW-1:0]  req_index;
    logic [TAGW-1:0]  req_tag;
    logic [IDXW-1:0]  fill_index;
    logic [TAGW-1:0]  fill_tag;
    logic             line_valid;
    logic [TAGW-1:0]  line_tag;
    logic [NBITS-1:0] line_data;
    logic             tag_hit;
    logic             read_hit;
    logic             arr_we;
    logic [IDXW-1:0]  arr_index;
    logic [TAGW-1:0]  arr_tag;
    logic [NBITS-1:0] arr_data;

    assign req_index  = address[IDXW-1:0];
    assign req_tag    = address[NBITS-1:IDXW];
    assign fill_index = mem.mem_addr[IDXW-1:0];
    assign fill_tag   = mem.mem_addr[NBITS-1:IDXW];

    dcache_array #(
        .NBITS  (NBITS),
        .NLINES (NLINES)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .rd_index (req_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_index (arr_index),
        .wr_tag   (arr_tag),
        .wr_data  (arr_data)
    );

    assign tag_hit   = line_valid && (line_tag == req_tag);
    assign read_hit  = !reset && (state == IDLE) && MemRead && !MemWrite && tag_hit;
    assign ReadData  = read_hit ? line_data : '0;
    assign dbg_state = state;

    always_comb begin
        busy = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    busy = MemWrite || (MemRead && !tag_hit);
                FILL:    busy = 1'b1;
                WRITE:   busy = !mem.mem_ack;
                default: busy = 1'b0;
            endcase
        end
    end

    // Single array write port: store hits update in IDLE, fills land from the latched address.
    always_comb begin
        arr_we    = 1'b0;
        arr_index = req_index;
        arr_tag   = req_tag;
        arr_data  = WriteData;
        if (!reset) begin
            if (state == IDLE && MemWrite && tag_hit) begin
                arr_we = 1'b1;
            end else if (state == FILL && mem.mem_ack) begin
                arr_we    = 1'b1;
                arr_index = fill_index;
                arr_tag   = fill_tag;
                arr_data  = mem.mem_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            fill_done     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemWrite) begin
                        state         <= WRITE;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= address;
                        mem.mem_wdata <= WriteData;
                    end else if (MemRead) begin
                        if (tag_hit) begin
                            // The replay right after a fill is the missed load completing.
                            if (!fill_done) begin
                                hit_count <= hit_count + CNT_ONE;
                            end
                        end else begin
                            state        <= FILL;
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= address;
                            miss_count   <= miss_count + CNT_ONE;
                        end
                    end
                end
                FILL: begin
                    if (mem.mem_ack) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        fill_done   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
